// File: rtl/exc_commit_ctrl.sv
// Exception commit sequencer: kills the committing instruction, drains the data bus,
// flushes the pipeline and hands CP0's target PC to fetch. Optional macro: EXC_DRAIN_TIMEOUT_EN.
module exc_commit_ctrl #(
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        cp0_exc_occur,
  input  logic [31:0] cp0_pc,
  input  logic        mem_outstanding,
  input  logic        redirect_ready,
  output logic        cp0_reg_valid,
  output logic        wb_kill,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    REDIRECT
  } state_e;

  state_e      state_q;
  logic [31:0] redirect_pc_q;

  if (DRAIN_TIMEOUT < 2) begin : gen_bad_param
    $error("exc_commit_ctrl: DRAIN_TIMEOUT must be at least 2");
  end

`ifdef EXC_DRAIN_TIMEOUT_EN
  localparam int CW = $clog2(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_TIMEOUT - 1);

  logic [CW-1:0] drain_cnt_q;
  logic          drain_timeout_q;
`endif

  // Only IDLE accepts an exception, so anything CP0 raises mid-sequence is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_pc_q <= 32'h0;
`ifdef EXC_DRAIN_TIMEOUT_EN
      drain_cnt_q     <= '0;
      drain_timeout_q <= 1'b0;
`endif
    end else begin
`ifdef EXC_DRAIN_TIMEOUT_EN
      drain_timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (cp0_exc_occur) begin
            redirect_pc_q <= cp0_pc;
            state_q       <= mem_outstanding ? DRAIN : FLUSH;
`ifdef EXC_DRAIN_TIMEOUT_EN
            drain_cnt_q   <= '0;
`endif
          end
        end
        DRAIN: begin
          if (!mem_outstanding) begin
            state_q <= FLUSH;
          end
`ifdef EXC_DRAIN_TIMEOUT_EN
          else if (drain_cnt_q == CNT_MAX) begin
            state_q         <= FLUSH;
            drain_timeout_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
`endif
        end
        FLUSH: begin
          state_q <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // reg_valid depends only on state, keeping exc_occur -> reg_valid free of a loop through CP0.
  assign cp0_reg_valid  = wb_valid && (state_q == IDLE);
  assign wb_kill        = cp0_exc_occur && (state_q == IDLE);
  assign stall          = (state_q != IDLE);
  assign flush          = (state_q == FLUSH);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_pc_q;

`ifdef EXC_DRAIN_TIMEOUT_EN
  assign drain_timeout = drain_timeout_q;
`else
  assign drain_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: each exception's expected timeline and PC is queued
// by the driver and a negedge monitor compares the DUT against it (EXC_DRAIN_TIMEOUT_EN aware).
module tb_exc_commit_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        cp0_exc_occur;
  logic [31:0] cp0_pc;
  logic        mem_outstanding;
  logic        redirect_ready;
  logic        cp0_reg_valid;
  logic        wb_kill;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        drain_timeout;

  exc_commit_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .cp0_exc_occur  (cp0_exc_occur),
    .cp0_pc         (cp0_pc),
    .mem_outstanding(mem_outstanding),
    .redirect_ready (redirect_ready),
    .cp0_reg_valid  (cp0_reg_valid),
    .wb_kill        (wb_kill),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .drain_timeout  (drain_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One accepted exception: issue cycle, effective drain length, ready delay, target PC.
  typedef struct {
    int          t;
    int          keff;
    int          r;
    logic [31:0] pc;
    bit          to;
  } txn_t;

  txn_t sb[$];
  int   passCount  = 0;
  int   checkCount = 0;
  bit   monOn      = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  task automatic applyStimulus(input bit exc, input bit wb, input logic [31:0] pc,
                               input bit mem, input bit rdy);
    cp0_exc_occur   = exc;
    wb_valid        = wb;
    cp0_pc          = pc;
    mem_outstanding = mem;
    redirect_ready  = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k: cycles mem_outstanding stays high starting at the exception cycle,
  // r: cycles redirect_ready is withheld once REDIRECT begins.
  task automatic runException(input logic [31:0] pc, input int k, input int r,
                              input bit nest, input bit wbv);
    txn_t x;
    int   keff;
    bit   to;
    int   last;
    keff = k;
    to   = 1'b0;
`ifdef EXC_DRAIN_TIMEOUT_EN
    if (k > TO) begin
      keff = TO;
      to   = 1'b1;
    end
`endif
    step();
    x.t = cyc; x.keff = keff; x.r = r; x.pc = pc; x.to = to;
    sb.push_back(x);
    applyStimulus(1'b1, wbv, pc, k > 0, $urandom_range(0, 1) == 1);
    last = keff + 2 + r;
    for (int j = 1; j <= last; j++) begin
      step();
      applyStimulus(nest ? ($urandom_range(0, 1) == 1) : 1'b0,
                    $urandom_range(0, 1) == 1, $urandom, j < k,
                    (j == last) ? 1'b1 :
                    ((j < keff + 2) ? ($urandom_range(0, 1) == 1) : 1'b0));
    end
    step();
    applyStimulus(1'b0, $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
  endtask

  // Expected behaviour follows from the front transaction's timeline alone.
  always @(negedge clk) begin
    int hs;
    bit busy, fl, rv, dto;
    if (monOn) begin
      hs = 0; busy = 1'b0; fl = 1'b0; rv = 1'b0; dto = 1'b0;
      if (sb.size() > 0) begin
        hs   = sb[0].t + 2 + sb[0].keff + sb[0].r;
        busy = (cyc > sb[0].t) && (cyc <= hs);
        fl   = (cyc == sb[0].t + 1 + sb[0].keff);
        rv   = (cyc >= sb[0].t + 2 + sb[0].keff) && (cyc <= hs);
        dto  = sb[0].to && fl;
      end
      checkOutput("stall", stall, busy);
      checkOutput("flush", flush, fl);
      checkOutput("redirect_valid", redirect_valid, rv);
      checkOutput("drain_timeout", drain_timeout, dto);
      checkOutput("cp0_reg_valid", cp0_reg_valid, wb_valid && !busy);
      checkOutput("wb_kill", wb_kill, cp0_exc_occur && !busy);
      if (redirect_valid && sb.size() > 0)
        checkOutput("redirect_pc", redirect_pc, sb[0].pc);
      if (sb.size() == 0) begin
        checkOutput("spurious_redirect", redirect_valid, 1'b0);
      end else if (redirect_valid && redirect_ready) begin
        checkOutput("redirect_cycle", cyc, hs);
        void'(sb.pop_front());
      end else if (cyc >= hs) begin
        checkOutput("redirect_handshake", redirect_valid && redirect_ready, 1'b1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    txn_t x;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_stall", stall, 1'b0);
    checkOutput("reset_flush", flush, 1'b0);
    checkOutput("reset_redirect_valid", redirect_valid, 1'b0);
    checkOutput("reset_redirect_pc", redirect_pc, 32'h0);
    checkOutput("reset_drain_timeout", drain_timeout, 1'b0);
    checkOutput("reset_wb_kill", wb_kill, 1'b0);
    checkOutput("reset_cp0_reg_valid", cp0_reg_valid, 1'b1);
    monOn = 1'b1;

    runException(32'hBFC00380, 0, 0, 1'b0, 1'b1);
    runException(32'hBFC00200, 3, 0, 1'b0, 1'b1);
    runException(32'h8000_0180, 0, 4, 1'b0, 1'b1);
    runException(32'h8000_1234, 2, 3, 1'b1, 1'b1);
    runException(32'hBFC00380, 1, 1, 1'b0, 1'b0);

    // Reset in the middle of a drain abandons the sequence.
    step();
    x.t = cyc; x.keff = 8; x.r = 0; x.pc = 32'hCAFE_0000; x.to = 1'b0;
    sb.push_back(x);
    applyStimulus(1'b1, 1'b1, 32'hCAFE_0000, 1'b1, 1'b0);
    repeat (2) begin
      step();
      applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b0);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("rst_mid_redirect_pc", redirect_pc, 32'h0);
    checkOutput("rst_mid_stall", stall, 1'b0);
    checkOutput("rst_mid_flush", flush, 1'b0);
    checkOutput("rst_mid_redirect_valid", redirect_valid, 1'b0);

    runException(32'hBFC00380, 20, 1, 1'b1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      runException($urandom, $urandom_range(0, 6), $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    repeat (3) step();
    checkOutput("scoreboard_empty", sb.size(), 0);
    monOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
